cache_ctrl_4way: RTL and testbench

Control FSM for the 4-way set-associative L1 cache.
- Sequences tag check, dirty-victim writeback and line allocation from physical memory.
- Maintains per-set tree pseudo-LRU state.
- Drives the one-hot way-select lines into the 4-way writeback/read data selector and the per-way load enables of the data/tag arrays.
- Sits between the CPU memory port and the physical-memory (pmem) port; the datapath holds the arrays and muxes.

---
 rtl/cache_ctrl_4way.sv | 180 ++++++++++++++++++
 tb/tb_cache_ctrl_4way.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_4way.sv
// cache_ctrl_4way: control FSM for a 4-way set-associative L1 cache.
// It sequences tag check, dirty-victim writeback and line allocation, and keeps
// a 3-bit tree pseudo-LRU per set. The datapath owns the arrays and muxes; this
// block steers them through way_sel / way_load and the select lines.
module cache_ctrl_4way #(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [3:0]       hit,
    input  logic [3:0]       valid,
    input  logic [3:0]       dirty,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel,
    output logic [3:0]       way_sel,
    output logic [3:0]       way_load,
    output logic             data_in_sel,
    output logic             dirty_set
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        ALLOCATE
    } state_e;

    state_e     state_q;
    logic [1:0] victim_q;
    logic [1:0] victim_d;
    logic [2:0] plru_q [NUM_SETS];

    logic       req;
    logic       isWrite;
    logic       anyHit;
    logic       allValid;
    logic [1:0] hitWay;
    logic [1:0] freeWay;
    logic [1:0] plruVictim;
    logic [2:0] plruCur;
    logic [2:0] plruNext;

    function automatic logic [3:0] oneHot(input logic [1:0] w);
        return 4'b0001 << w;
    endfunction

    // A simultaneous read and write is handled as a write.
    assign req      = mem_read | mem_write;
    assign isWrite  = mem_write;
    assign anyHit   = |hit;
    assign allValid = &valid;
    assign plruCur  = plru_q[set_idx];

    // Hit way uses hit[3] priority so it agrees with the datapath's selector.
    always_comb begin
        hitWay = 2'd0;
        if (hit[3]) begin
            hitWay = 2'd3;
        end else if (hit[2]) begin
            hitWay = 2'd2;
        end else if (hit[1]) begin
            hitWay = 2'd1;
        end
    end

    // Victim choice: lowest invalid way first, otherwise follow the PLRU tree.
    always_comb begin
        freeWay = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!valid[i]) begin
                freeWay = 2'(i);
            end
        end
        plruVictim = plruCur[0] ? {1'b1, plruCur[2]} : {1'b0, plruCur[1]};
        victim_d   = allValid ? plruVictim : freeWay;
    end

    // PLRU update for an access to the hit way: point the tree away from it.
    always_comb begin
        plruNext = plruCur;
        if (!hitWay[1]) begin
            plruNext[0] = 1'b1;
            plruNext[1] = ~hitWay[0];
        end else begin
            plruNext[0] = 1'b0;
            plruNext[2] = ~hitWay[0];
        end
    end

    // Controller state, registered victim and per-set PLRU bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= 2'd0;
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= 3'b000;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (anyHit) begin
                        plru_q[set_idx] <= plruNext;
                        state_q         <= IDLE;
                    end else begin
                        victim_q <= victim_d;
                        state_q  <= dirty[victim_d] ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state_q <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        state_q <= CHECK;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode from the current state; the pmem requests are pure state
    // decodes so an asynchronous reset removes them immediately.
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        way_sel       = 4'b0000;
        way_load      = 4'b0000;
        data_in_sel   = 1'b0;
        dirty_set     = 1'b0;
        case (state_q)
            CHECK: begin
                if (anyHit) begin
                    mem_resp = 1'b1;
                    way_sel  = oneHot(hitWay);
                    if (isWrite) begin
                        way_load    = oneHot(hitWay);
                        dirty_set   = 1'b1;
                        data_in_sel = 1'b0;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = oneHot(victim_q);
            end
            ALLOCATE: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = 1'b0;
                if (pmem_resp) begin
                    way_load    = oneHot(victim_q);
                    data_in_sel = 1'b1;
                    dirty_set   = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_4way.sv
// tb_cache_ctrl_4way: drives whole CPU transactions into cache_ctrl_4way and
// compares every cycle against a tree-PLRU reference model of the cache policy.
module tb_cache_ctrl_4way;

    logic       clk;
    logic       rst_n;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] set_idx;
    logic [3:0] hit;
    logic [3:0] valid;
    logic [3:0] dirty;
    logic       pmem_resp;
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_addr_sel;
    logic [3:0] way_sel;
    logic [3:0] way_load;
    logic       data_in_sel;
    logic       dirty_set;

    int checkCount;
    int errorCount;

    // Reference policy: per set, which half of the tree is least recent, and
    // which way inside each half is least recent.
    bit rootRight [8];
    bit leftLru   [8];
    bit rightLru  [8];

    cache_ctrl_4way #(.NUM_SETS(8), .IDX_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .set_idx      (set_idx),
        .hit          (hit),
        .valid        (valid),
        .dirty        (dirty),
        .pmem_resp    (pmem_resp),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_addr_sel(pmem_addr_sel),
        .way_sel      (way_sel),
        .way_load     (way_load),
        .data_in_sel  (data_in_sel),
        .dirty_set    (dirty_set)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] wayBit(input int w);
        logic [3:0] v;
        v = 4'b0000;
        v[w] = 1'b1;
        return v;
    endfunction

    function automatic int modelVictim(input int s, input logic [3:0] vld);
        for (int i = 0; i < 4; i++) begin
            if (!vld[i]) return i;
        end
        return rootRight[s] ? (2 + int'(rightLru[s])) : int'(leftLru[s]);
    endfunction

    function automatic void modelTouch(input int s, input int w);
        if (w < 2) begin
            rootRight[s] = 1'b1;
            leftLru[s]   = (w == 0);
        end else begin
            rootRight[s] = 1'b0;
            rightLru[s]  = (w == 2);
        end
    endfunction

    function automatic void modelClear();
        for (int s = 0; s < 8; s++) begin
            rootRight[s] = 1'b0;
            leftLru[s]   = 1'b0;
            rightLru[s]  = 1'b0;
        end
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Check a CHECK cycle that hits; hit must already be driven.
    task automatic checkHitCycle(input int s, input bit wr, input logic [3:0] hitV);
        int h;
        h = 0;
        for (int i = 0; i < 4; i++) begin
            if (hitV[i]) h = i;
        end
        @(negedge clk);
        checkOutput("hit_resp",    32'(mem_resp), 32'd1);
        checkOutput("hit_way_sel", 32'(way_sel), 32'(wayBit(h)));
        checkOutput("hit_way_load", 32'(way_load), wr ? 32'(wayBit(h)) : 32'd0);
        checkOutput("hit_pmem", 32'({pmem_read, pmem_write}), 32'd0);
        if (wr) begin
            checkOutput("hit_dirty_set", 32'(dirty_set), 32'd1);
            checkOutput("hit_data_sel",  32'(data_in_sel), 32'd0);
        end
        modelTouch(s, h);
    endtask

    // One complete CPU transaction starting from IDLE at posedge+1.
    task automatic applyStimulus(input int s, input bit wr, input logic [3:0] hitV,
                                 input logic [3:0] vld, input logic [3:0] drt,
                                 input int wbLat, input int alLat, input bit spurious);
        int v;
        mem_write = wr;
        mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        set_idx   = 3'(s);
        hit       = 4'b0000;
        valid     = vld;
        dirty     = drt;
        pmem_resp = spurious;
        @(negedge clk);
        checkOutput("idle_outputs", 32'({mem_resp, pmem_read, pmem_write, way_sel, way_load}), 32'd0);
        nextCycle();
        pmem_resp = 1'b0;
        hit       = hitV;
        if (hitV != 4'b0000) begin
            checkHitCycle(s, wr, hitV);
        end else begin
            v = modelVictim(s, vld);
            @(negedge clk);
            checkOutput("miss_outputs", 32'({mem_resp, pmem_read, pmem_write, way_sel, way_load}), 32'd0);
            hit = 4'b0000;
            if (drt[v]) begin
                for (int i = 0; i < wbLat; i++) begin
                    nextCycle();
                    pmem_resp = (i == wbLat - 1);
                    @(negedge clk);
                    checkOutput("wb_req",     32'({pmem_write, pmem_addr_sel, pmem_read}), 32'b110);
                    checkOutput("wb_way_sel", 32'(way_sel), 32'(wayBit(v)));
                    checkOutput("wb_quiet",   32'({mem_resp, way_load}), 32'd0);
                end
            end
            for (int i = 0; i < alLat; i++) begin
                nextCycle();
                pmem_resp = (i == alLat - 1);
                @(negedge clk);
                checkOutput("al_req",  32'({pmem_read, pmem_write, pmem_addr_sel, mem_resp}), 32'b1000);
                checkOutput("al_load", 32'(way_load), (i == alLat - 1) ? 32'(wayBit(v)) : 32'd0);
                if (i == alLat - 1) begin
                    checkOutput("al_sel", 32'({data_in_sel, dirty_set}), 32'b10);
                end
            end
            nextCycle();
            pmem_resp = 1'b0;
            hit       = wayBit(v);
            checkHitCycle(s, wr, wayBit(v));
        end
        nextCycle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit       = 4'b0000;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        modelClear();
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        set_idx   = 3'd0;
        hit       = 4'b0000;
        valid     = 4'b0000;
        dirty     = 4'b0000;
        pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs",
                    32'({mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, way_load, data_in_sel, dirty_set}), 32'd0);
        rst_n = 1'b1;
        nextCycle();

        $display("[TB] directed transactions");
        applyStimulus(2, 1'b0, 4'b0100, 4'hF, 4'h0, 1, 1, 1'b0);
        applyStimulus(0, 1'b1, 4'b1010, 4'hF, 4'h0, 1, 1, 1'b0);
        applyStimulus(1, 1'b0, 4'b0000, 4'b0011, 4'h0, 1, 3, 1'b0);
        applyStimulus(3, 1'b0, 4'b0000, 4'hF, 4'b0001, 2, 2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(5, 1'b0, 4'b0000, 4'hF, 4'h0, 1, 1, 1'b0);
        end

        $display("[TB] random transactions");
        for (int k = 0; k < 80; k++) begin
            applyStimulus($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                          ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom),
                          4'($urandom), $urandom_range(1, 4), $urandom_range(1, 4),
                          1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during allocate");
        applyStimulus(6, 1'b0, 4'b0001, 4'hF, 4'h0, 1, 1, 1'b0);
        mem_read = 1'b1;
        set_idx  = 3'd6;
        valid    = 4'hF;
        dirty    = 4'h0;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("pre_reset_al", 32'(pmem_read), 32'd1);
        nextCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_abort", 32'({pmem_read, pmem_write, mem_resp, way_load}), 32'd0);
        modelClear();
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("post_reset_idle", 32'({mem_resp, pmem_read, pmem_write, way_sel}), 32'd0);
        nextCycle();
        applyStimulus(6, 1'b0, 4'b0000, 4'hF, 4'h0, 1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
